tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the HDMI TMDS transmit path. It takes raw 10-bit parallel words from one TMDS channel's deserializer in the pixel-clock domain. It finds the symbol boundary by bit-slipping until control tokens are seen, then decodes each symbol into either a control pair or an 8-bit data byte. One instance is used per channel; the blue-channel instance supplies HSYNC/VSYNC through `ctrl`.

## Interface
- `CTRL_RUN`, default 8: consecutive control tokens needed to declare lock.
- `SEARCH_WINDOW`, default 1024: cycles spent at one bit offset before slipping.
- `LOSS_TIMEOUT`, default 4096: cycles without any control token before lock is dropped.
- `clk_low`, input, 1: pixel clock; one 10-bit word per cycle.
- `reset`, input, 1: synchronous, active-low; `reset==0` at a `clk_low` edge resets the block.
- `raw`, input, 10: deserialized word; `raw[0]` is the earliest-received bit.
- `de`, output, 1: data enable; 1 = `data` valid, 0 = control period.
- `ctrl`, output, 2: decoded control bits {C1,C0}.
- `data`, output, 8: decoded pixel byte.
- `locked`, output, 1: symbol alignment established.
- `offset`, output, 4: current bit-slip offset, range 0..9.

## Operation
- **Input and window**
  - Registers: `r_cur <= raw`, `r_prev <= r_cur`.
  - Window word `r_word <= {r_cur, r_prev}[offset+9 : offset]`.
  - Offset 0 selects `r_prev` unchanged.
- **Control tokens** (compared against `r_word`):
  - 10'b1101010100 -> 00
  - 10'b0010101011 -> 01
  - 10'b0101010100 -> 10
  - 10'b1010101011 -> 11
- **Data decode** (any non-token word):
  - `d = r_word[9] ? ~r_word[7:0] : r_word[7:0]`.
  - `data[0] = d[0]`.
  - For i = 1..7: `data[i] = r_word[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])`.
- **FSM states:** SEARCH (reset state), SETTLE, LOCKED.
- **SEARCH**
  - `search_cnt` increments every cycle.
  - `run_cnt` increments on a token and clears on a non-token.
  - When a token arrives with `run_cnt == CTRL_RUN-1`: go to LOCKED, clear counters.
  - Otherwise, when `search_cnt == SEARCH_WINDOW-1`: `offset <= (offset==9) ? 0 : offset+1`, clear counters, go to SETTLE.
  - If both conditions are true in the same cycle, lock wins and the offset does not change.
- **SETTLE**
  - Lasts 2 cycles so the pipeline flushes the old alignment.
  - Counters are held at 0, then the FSM returns to SEARCH.
- **LOCKED**
  - `loss_cnt` increments every cycle and clears on any token.
  - At `loss_cnt == LOSS_TIMEOUT-1` with a non-token: go to SEARCH, clear counters, keep `offset`.
- **Output gating:** while `locked==0`, `de`, `ctrl` and `data` are forced to 0.
- **Reset values:** `de=0`, `ctrl=0`, `data=0`, `locked=0`, `offset=0`, FSM=SEARCH, all counters 0, `r_cur`/`r_prev`/`r_word` cleared to 0.
- **Reset mid-operation** (any state): all of the above are restored on the next edge.
- **Counter widths:** sized by `$clog2` of the respective parameter. Counters never wrap, because each one is cleared at its terminal count.

## Timing
- Decode latency is a fixed 3 `clk_low` edges: `raw` is sampled at edge N, the window at N+2, the outputs registered at N+3.
  - This latency is independent of `offset`. For `offset > 0`, the upper bits come from the word sampled at N+1.
- `locked` rises on the edge after the `CTRL_RUN`-th consecutive token is seen in `r_word`.
  - For an aligned stream from reset: `locked` rises at edge 2+`CTRL_RUN`+1.
- `locked` falls on the edge after the timeout condition.
- Outputs from the same `r_word` that triggered the lock are already ungated.
- `offset` changes exactly on the slip edge. Worst-case acquisition is ≈10×(`SEARCH_WINDOW`+2) cycles plus the token run.

## Test plan
- **Reset:** `reset=0` for 5 cycles with random `raw` -> `de=0`, `ctrl=0`, `data=0`, `locked=0`, `offset=0`; outputs still 0 on the first cycle after release.
- **Aligned lock and decode:** 16× 10'b1101010100, then 10'h100, then 10'h200 -> `locked` rises 11 edges after reset release with `ctrl=00`, `de=0`. Then `de=1` with `data=8'h00`, followed by `data=8'hFF`, 3 cycles after the words were applied.
- **Misaligned stream:** continuous 10'b0101010100 tokens with the boundary at window bit 3 -> slips at `search_cnt` terminals, `offset=3` after 3 slips, `locked=1`, `ctrl=10`. `offset` stays at 3 for 10000 further token cycles.
- **Loss boundary:** after lock, send 4095 data words then one token -> `locked` stays 1. Repeat with 4096 data words -> `locked` falls after the 4096th, `offset` is unchanged, and relock happens after 8 tokens.
- **Simultaneous lock/slip:** preload so the 8th token lands on cycle `SEARCH_WINDOW-1` -> `locked=1` and `offset` is unchanged. Then pull `reset=0` for one cycle while locked -> all outputs 0 and FSM=SEARCH on the next edge.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: bit-slip word alignment on control-token runs, then
// per-symbol decode into a control pair or an 8-bit pixel byte.
module tmds_channel_decoder #(
   parameter int CTRL_RUN      = 8,
   parameter int SEARCH_WINDOW = 1024,
   parameter int LOSS_TIMEOUT  = 4096
) (
   input  logic       clk_low,
   input  logic       reset,
   input  logic [9:0] raw,
   output logic       de,
   output logic [1:0] ctrl,
   output logic [7:0] data,
   output logic       locked,
   output logic [3:0] offset
);

   localparam int RUN_W    = (CTRL_RUN > 1)      ? $clog2(CTRL_RUN)      : 1;
   localparam int SEARCH_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
   localparam int LOSS_W   = (LOSS_TIMEOUT > 1)  ? $clog2(LOSS_TIMEOUT)  : 1;

   localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(CTRL_RUN - 1);
   localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_WINDOW - 1);
   localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_SETTLE,
      S_LOCKED
   } state_t;

   state_t              state, state_nxt;
   logic [9:0]          r_cur, r_prev, r_word;
   logic [19:0]         win;
   logic [RUN_W-1:0]    run_cnt, run_cnt_nxt;
   logic [SEARCH_W-1:0] search_cnt, search_cnt_nxt;
   logic [LOSS_W-1:0]   loss_cnt, loss_cnt_nxt;
   logic                settle_cnt, settle_cnt_nxt;
   logic [3:0]          offset_nxt;
   logic                is_tok;
   logic [1:0]          tok_ctrl;
   logic [7:0]          d, dec_data;

   assign win = {r_cur, r_prev};

   // Two-word window so any of the 10 bit offsets yields a full symbol.
   always_ff @(posedge clk_low) begin
      if (!reset) begin
         r_cur  <= '0;
         r_prev <= '0;
         r_word <= '0;
      end else begin
         r_cur  <= raw;
         r_prev <= r_cur;
         r_word <= win[offset +: 10];
      end
   end

   always_comb begin
      is_tok   = 1'b1;
      tok_ctrl = 2'b00;
      case (r_word)
         10'b1101010100: tok_ctrl = 2'b00;
         10'b0010101011: tok_ctrl = 2'b01;
         10'b0101010100: tok_ctrl = 2'b10;
         10'b1010101011: tok_ctrl = 2'b11;
         default:        is_tok   = 1'b0;
      endcase
   end

   // Undo the transmitter's optional inversion, then its XOR/XNOR chain.
   always_comb begin
      d        = r_word[9] ? ~r_word[7:0] : r_word[7:0];
      dec_data = '0;
      dec_data[0] = d[0];
      for (int i = 1; i < 8; i++)
         dec_data[i] = r_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
   end

   always_ff @(posedge clk_low) begin
      if (!reset) begin
         state      <= S_SEARCH;
         run_cnt    <= '0;
         search_cnt <= '0;
         loss_cnt   <= '0;
         settle_cnt <= 1'b0;
         offset     <= '0;
      end else begin
         state      <= state_nxt;
         run_cnt    <= run_cnt_nxt;
         search_cnt <= search_cnt_nxt;
         loss_cnt   <= loss_cnt_nxt;
         settle_cnt <= settle_cnt_nxt;
         offset     <= offset_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      run_cnt_nxt    = run_cnt;
      search_cnt_nxt = search_cnt;
      loss_cnt_nxt   = loss_cnt;
      settle_cnt_nxt = settle_cnt;
      offset_nxt     = offset;
      case (state)
         S_SEARCH: begin
            // Lock is tested first so a lock on the window's last cycle keeps the offset.
            if (is_tok && run_cnt == RUN_LAST) begin
               state_nxt      = S_LOCKED;
               run_cnt_nxt    = '0;
               search_cnt_nxt = '0;
               loss_cnt_nxt   = '0;
            end else if (search_cnt == SEARCH_LAST) begin
               state_nxt      = S_SETTLE;
               offset_nxt     = (offset == 4'd9) ? 4'd0 : offset + 4'd1;
               run_cnt_nxt    = '0;
               search_cnt_nxt = '0;
               settle_cnt_nxt = 1'b0;
            end else begin
               search_cnt_nxt = search_cnt + 1'b1;
               run_cnt_nxt    = is_tok ? run_cnt + 1'b1 : '0;
            end
         end
         S_SETTLE: begin
            // Two cycles let r_word refill from the new offset before counting again.
            run_cnt_nxt    = '0;
            search_cnt_nxt = '0;
            if (settle_cnt) begin
               state_nxt      = S_SEARCH;
               settle_cnt_nxt = 1'b0;
            end else begin
               settle_cnt_nxt = 1'b1;
            end
         end
         S_LOCKED: begin
            if (is_tok) begin
               loss_cnt_nxt = '0;
            end else if (loss_cnt == LOSS_LAST) begin
               state_nxt      = S_SEARCH;
               loss_cnt_nxt   = '0;
               run_cnt_nxt    = '0;
               search_cnt_nxt = '0;
            end else begin
               loss_cnt_nxt = loss_cnt + 1'b1;
            end
         end
         default: state_nxt = S_SEARCH;
      endcase
   end

   // Gate on the next state so the word that completes the lock is already visible.
   always_ff @(posedge clk_low) begin
      if (!reset) begin
         de     <= 1'b0;
         ctrl   <= 2'b00;
         data   <= 8'h00;
         locked <= 1'b0;
      end else begin
         locked <= (state_nxt == S_LOCKED);
         if (state_nxt == S_LOCKED) begin
            de   <= ~is_tok;
            ctrl <= is_tok ? tok_ctrl : 2'b00;
            data <= is_tok ? 8'h00 : dec_data;
         end else begin
            de   <= 1'b0;
            ctrl <= 2'b00;
            data <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, aligned lock/decode,
// bit-slip acquisition, loss timeout boundary and lock-vs-slip priority.
module tb_tmds_channel_decoder;

   localparam logic [9:0] T0    = 10'b1101010100;
   // 10'b0101010100 rotated so it only appears at window offset 3
   localparam logic [9:0] R_MIS = 10'b1010100010;

   logic       clk_low = 1'b0;
   logic       reset;
   logic [9:0] raw;
   logic       de;
   logic [1:0] ctrl;
   logic [7:0] data;
   logic       locked;
   logic [3:0] offset;

   int n_chk  = 0;
   int n_fail = 0;

   tmds_channel_decoder dut (
      .clk_low (clk_low),
      .reset   (reset),
      .raw     (raw),
      .de      (de),
      .ctrl    (ctrl),
      .data    (data),
      .locked  (locked),
      .offset  (offset)
   );

   always #5 clk_low = ~clk_low;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic [9:0] w);
      raw = w;
      @(posedge clk_low);
      #1;
   endtask

   initial begin
      logic ok;
      reset = 1'b0;
      raw   = '0;

      // reset with random input
      for (int i = 0; i < 5; i++) cyc(10'($urandom_range(0, 1023)));
      chk("rst_de",     32'(de),     32'd0);
      chk("rst_ctrl",   32'(ctrl),   32'd0);
      chk("rst_data",   32'(data),   32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_offset", 32'(offset), 32'd0);

      // aligned stream: lock on edge 11 after release
      reset = 1'b1;
      cyc(T0);
      chk("rel_outs", 32'({de, ctrl, data, locked}), 32'd0);
      for (int e = 2; e <= 16; e++) begin
         cyc(T0);
         if (e == 10) chk("lock_e10", 32'(locked), 32'd0);
         if (e == 11) begin
            chk("lock_e11", 32'(locked), 32'd1);
            chk("lock_ctrl", 32'(ctrl), 32'd0);
            chk("lock_de", 32'(de), 32'd0);
         end
      end
      cyc(10'h100);
      cyc(10'h200);
      cyc(T0);
      cyc(T0);
      chk("dec00_de",   32'(de),   32'd1);
      chk("dec00_data", 32'(data), 32'h00);
      cyc(T0);
      chk("decff_de",   32'(de),   32'd1);
      chk("decff_data", 32'(data), 32'hFF);
      cyc(T0);
      chk("tok_de",   32'(de),   32'd0);
      chk("tok_ctrl", 32'(ctrl), 32'd0);

      // loss boundary: 4095 data words keep the lock
      ok = 1'b1;
      for (int i = 0; i < 4095; i++) begin cyc(10'h100); ok &= locked; end
      for (int i = 0; i < 8; i++)    begin cyc(T0);      ok &= locked; end
      chk("loss_4095", 32'(ok), 32'd1);

      // 4096 data words drop it three edges after the last one
      ok = 1'b1;
      for (int i = 0; i < 4096; i++) begin cyc(10'h100); ok &= locked; end
      chk("loss_hold", 32'(ok), 32'd1);
      cyc(T0);
      cyc(T0);
      chk("loss_x2", 32'(locked), 32'd1);
      cyc(T0);
      chk("loss_drop",   32'(locked), 32'd0);
      chk("loss_offset", 32'(offset), 32'd0);
      for (int i = 0; i < 7; i++) cyc(T0);
      chk("relock_pre", 32'(locked), 32'd0);
      cyc(T0);
      chk("relock", 32'(locked), 32'd1);

      // misaligned: slips at 1024, 2050, 3076; lock at 3086
      reset = 1'b0;
      cyc(R_MIS);
      reset = 1'b1;
      for (int e = 1; e <= 3086; e++) begin
         cyc(R_MIS);
         if (e == 1023) chk("slip_pre", 32'(offset), 32'd0);
         if (e == 1024) chk("slip1",    32'(offset), 32'd1);
         if (e == 2050) chk("slip2",    32'(offset), 32'd2);
         if (e == 3085) chk("mis_pre",  32'(locked), 32'd0);
      end
      chk("mis_locked", 32'(locked), 32'd1);
      chk("mis_offset", 32'(offset), 32'd3);
      chk("mis_ctrl",   32'(ctrl),   32'd2);
      ok = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         cyc(R_MIS);
         ok &= (offset == 4'd3) && locked;
      end
      chk("mis_hold", 32'(ok), 32'd1);

      // reset while locked at offset 3
      reset = 1'b0;
      cyc(R_MIS);
      chk("mid_rst_offset", 32'(offset), 32'd0);
      chk("mid_rst_locked", 32'(locked), 32'd0);
      chk("mid_rst_ctrl",   32'(ctrl),   32'd0);
      reset = 1'b1;

      // 8th token sampled on the window's last cycle: lock wins
      for (int e = 1; e <= 1013; e++) cyc(10'h100);
      for (int e = 1014; e <= 1024; e++) begin
         cyc(T0);
         if (e == 1023) chk("sim_pre", 32'(locked), 32'd0);
      end
      chk("sim_locked", 32'(locked), 32'd1);
      chk("sim_offset", 32'(offset), 32'd0);
      for (int i = 0; i < 4; i++) cyc(10'h200);
      chk("sim_de",   32'(de),   32'd1);
      chk("sim_data", 32'(data), 32'hFF);

      reset = 1'b0;
      cyc(10'h200);
      chk("fin_rst_outs",   32'({de, ctrl, data}), 32'd0);
      chk("fin_rst_locked", 32'(locked), 32'd0);
      chk("fin_rst_offset", 32'(offset), 32'd0);
      reset = 1'b1;
      cyc(T0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
